axi4l_cfg_seq: RTL and testbench
================================

Name: axi4l_cfg_seq

Overview:
AXI4-Lite master that walks a configuration table and writes each entry to an AXI4-Lite register slave such as axi4l_slv_top. It is used for post-reset register initialisation without a CPU.
The table lives in an external synchronous memory with 1-cycle read latency; each entry is {addr, data}.
Status outputs are busy, done and err, plus an error index and error code.

Parameters:
C_ADDR_WIDTH, 12, AXI address width
C_DATA_WIDTH, 32, AXI data width (32 or 64)
C_TBL_DEPTH_LOG2, 8, table index width; up to 2**C_TBL_DEPTH_LOG2 entries
C_TIMEOUT, 256, max cycles from AW/W assertion to B handshake per entry (>=4)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to run the table
num_entries  in  C_TBL_DEPTH_LOG2+1  entry count, sampled on accepted start
busy  out  1  sequence in progress
done  out  1  sequence finished; sticky until next accepted start
err  out  1  sequence aborted; valid when done=1
err_code  out  2  00 none, 01 SLVERR, 10 DECERR, 11 timeout
err_index  out  C_TBL_DEPTH_LOG2  index of the failing entry
tbl_en  out  1  table read enable
tbl_addr  out  C_TBL_DEPTH_LOG2  table read index
tbl_rdata  in  C_ADDR_WIDTH+C_DATA_WIDTH  entry; {addr[MSBs], data[LSBs]}; valid 1 cycle after tbl_en
m_axi_awaddr  out  C_ADDR_WIDTH  write address
m_axi_awprot  out  3  constant 3'b000
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  C_DATA_WIDTH  write data
m_axi_wstrb  out  C_DATA_WIDTH/8  constant all-ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready

Behaviour:
- Reset values (asynchronous): state=IDLE. busy, done, err, tbl_en, awvalid, wvalid and bready are 0. err_code=0, err_index=0, tbl_addr=0, awaddr=0, wdata=0.
- States: IDLE, FETCH, LOAD, ISSUE, RESP, DRAIN.
- IDLE: start accepted only here. busy<=1, done<=0, err<=0, err_code<=0, count latched, idx<=0.
  - num_entries=0: go straight to IDLE with done<=1 and busy<=0 on the next cycle; no AXI traffic.
  - Otherwise go to FETCH.
- start while busy: ignored. No queueing.
- FETCH (1 cycle): tbl_en=1, tbl_addr=idx.
- LOAD (1 cycle): capture tbl_rdata into awaddr/wdata. awvalid<=1, wvalid<=1 together. Clear the timeout counter.
- ISSUE:
  - awvalid drops on the cycle after the awvalid&awready handshake; wvalid likewise on wvalid&wready.
  - The two channels complete independently, in either order or together.
  - Go to RESP when both handshakes have completed; bready<=1.
- RESP: on bvalid&bready, bready<=0.
  - bresp OKAY or EXOKAY: idx++. If idx+1==count, go to IDLE with done<=1 and busy<=0; otherwise go to FETCH.
  - bresp SLVERR or DECERR: err<=1, err_code=01/10, err_index=idx, done<=1, busy<=0; go to IDLE. No further entries.
- Timeout:
  - The counter runs in ISSUE and RESP. When it reaches C_TIMEOUT-1: err<=1, err_code=11, err_index=idx; go to DRAIN.
- DRAIN:
  - Valids already asserted are held until their handshake (AXI rule: valid never drops early).
  - bready is held until bvalid.
  - Then done<=1, busy<=0, go to IDLE. DRAIN has no timeout.
- Per-entry minimum latency: FETCH 1 + LOAD 1 + AW/W handshake ≥1 + B ≥1, so ≥4 cycles per entry with a zero-wait slave.
- awaddr and wdata stay stable while their valid is high.
- areset mid-sequence: all valids drop immediately. The sequence is lost and not resumed.

Decomposition:
- axi4l_pkg holds:
  - resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11)
  - cfg_seq_state_t enum
  - cfg_err_t enum (NONE, SLVERR, DECERR, TIMEOUT)
- Single module, no sub-module. The table memory is external; the bench supplies a behavioural array with 1-cycle latency.

Test Plan:
- 3-entry table {0x000:0xABCD1234, 0x008:0x5A5A0001, 0x00C:0xFFFF0000}, zero-wait slave, start -> 3 AW/W/B handshakes in table order; done=1, err=0; slave reg_a_b=0xABCD1234.
- Slave with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles; addr/data stable; done=1, err=0.
- Entry 1 gets bresp=2'b11 -> done=1, err=1, err_code=10, err_index=1; entry 2 never issued.
- bvalid withheld 300 cycles, C_TIMEOUT=256 -> err_code=11 at cycle 256; bready held until bvalid; done only after the B handshake.
- num_entries=0 -> done=1 one cycle after start; no AWVALID.
- areset asserted in ISSUE -> awvalid/wvalid/busy low immediately; a new start after release runs from entry 0; start pulses while busy are ignored.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the configuration sequencer: response codes,
// sequencer states and the error code reported on the status port.
package axi4l_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_RESP,
    ST_DRAIN
  } cfg_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_SLVERR  = 2'b01,
    ERR_DECERR  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } cfg_err_t;

  function automatic cfg_err_t resp_to_err(input resp_t resp);
    case (resp)
      RESP_SLVERR: return ERR_SLVERR;
      RESP_DECERR: return ERR_DECERR;
      default:     return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axi4l_cfg_seq.sv
// AXI4-Lite master that replays an {addr, data} table from a 1-cycle-latency
// memory as single-beat writes, stopping on the first error or timeout.
module axi4l_cfg_seq
  import axi4l_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 12,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_TBL_DEPTH_LOG2 = 8,
  parameter int C_TIMEOUT        = 256
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 start,
  input  logic [C_TBL_DEPTH_LOG2:0]            num_entries,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [1:0]                           err_code,
  output logic [C_TBL_DEPTH_LOG2-1:0]          err_index,
  output logic                                 tbl_en,
  output logic [C_TBL_DEPTH_LOG2-1:0]          tbl_addr,
  input  logic [C_ADDR_WIDTH+C_DATA_WIDTH-1:0] tbl_rdata,
  output logic [C_ADDR_WIDTH-1:0]              m_axi_awaddr,
  output logic [2:0]                           m_axi_awprot,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]              m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0]            m_axi_wstrb,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready
);

  localparam int IW = C_TBL_DEPTH_LOG2;
  localparam int TW = $clog2(C_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);

  cfg_seq_state_t            state, state_n;
  logic                      busy_n, done_n, err_n;
  cfg_err_t                  code, code_n;
  logic [IW-1:0]             err_index_n;
  logic                      tbl_en_n;
  logic [IW-1:0]             tbl_addr_n;
  logic [C_ADDR_WIDTH-1:0]   awaddr_n;
  logic [C_DATA_WIDTH-1:0]   wdata_n;
  logic                      awvalid_n, wvalid_n, bready_n;
  logic [IW-1:0]             idx, idx_n;
  logic [IW:0]               count, count_n;
  logic [TW-1:0]             tmo, tmo_n;

  logic aw_hs, w_hs, b_hs, tmo_hit, last;

  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = '1;
  assign err_code     = code;

  always_comb begin
    state_n     = state;
    busy_n      = busy;
    done_n      = done;
    err_n       = err;
    code_n      = code;
    err_index_n = err_index;
    tbl_en_n    = 1'b0;
    tbl_addr_n  = tbl_addr;
    awaddr_n    = m_axi_awaddr;
    wdata_n     = m_axi_wdata;
    awvalid_n   = m_axi_awvalid;
    wvalid_n    = m_axi_wvalid;
    bready_n    = m_axi_bready;
    idx_n       = idx;
    count_n     = count;
    tmo_n       = tmo;

    aw_hs   = m_axi_awvalid && m_axi_awready;
    w_hs    = m_axi_wvalid && m_axi_wready;
    b_hs    = m_axi_bvalid && m_axi_bready;
    tmo_hit = (tmo == TMO_LAST);
    last    = (({1'b0, idx} + (IW+1)'(1)) == count);

    case (state)
      ST_IDLE: begin
        // busy is only high in IDLE on the cycle after an empty-table start
        if (busy) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end else if (start) begin
          busy_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = 1'b0;
          code_n  = ERR_NONE;
          count_n = num_entries;
          idx_n   = '0;
          if (num_entries != '0) begin
            state_n    = ST_FETCH;
            tbl_en_n   = 1'b1;
            tbl_addr_n = '0;
          end
        end
      end

      ST_FETCH: state_n = ST_LOAD;

      ST_LOAD: begin
        awaddr_n  = tbl_rdata[C_ADDR_WIDTH+C_DATA_WIDTH-1:C_DATA_WIDTH];
        wdata_n   = tbl_rdata[C_DATA_WIDTH-1:0];
        awvalid_n = 1'b1;
        wvalid_n  = 1'b1;
        tmo_n     = '0;
        state_n   = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        tmo_n = tmo + TW'(1);
        if (tmo_hit) begin
          err_n       = 1'b1;
          code_n      = ERR_TIMEOUT;
          err_index_n = idx;
          bready_n    = 1'b1;
          state_n     = ST_DRAIN;
        end else if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = ST_RESP;
        end
      end

      ST_RESP: begin
        tmo_n = tmo + TW'(1);
        if (b_hs) begin
          bready_n = 1'b0;
          if (m_axi_bresp[1]) begin
            err_n       = 1'b1;
            code_n      = resp_to_err(resp_t'(m_axi_bresp));
            err_index_n = idx;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = ST_IDLE;
          end else if (last) begin
            idx_n   = idx + IW'(1);
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            idx_n      = idx + IW'(1);
            tbl_en_n   = 1'b1;
            tbl_addr_n = idx + IW'(1);
            state_n    = ST_FETCH;
          end
        end else if (tmo_hit) begin
          err_n       = 1'b1;
          code_n      = ERR_TIMEOUT;
          err_index_n = idx;
          state_n     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // outstanding handshakes must still complete before we can report done
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        if (b_hs)  bready_n  = 1'b0;
        if (!awvalid_n && !wvalid_n && !bready_n) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      code          <= ERR_NONE;
      err_index     <= '0;
      tbl_en        <= 1'b0;
      tbl_addr      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      idx           <= '0;
      count         <= '0;
      tmo           <= '0;
    end else begin
      state         <= state_n;
      busy          <= busy_n;
      done          <= done_n;
      err           <= err_n;
      code          <= code_n;
      err_index     <= err_index_n;
      tbl_en        <= tbl_en_n;
      tbl_addr      <= tbl_addr_n;
      m_axi_awaddr  <= awaddr_n;
      m_axi_wdata   <= wdata_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_wvalid  <= wvalid_n;
      m_axi_bready  <= bready_n;
      idx           <= idx_n;
      count         <= count_n;
      tmo           <= tmo_n;
    end
  end

endmodule

// File: tb/tb_axi4l_cfg_seq.sv
// Bench for axi4l_cfg_seq: randomized AXI4-Lite slave with scoreboarded
// address/data ordering and end-of-sequence status.
module tb_axi4l_cfg_seq;
  import axi4l_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int IW  = 8;
  localparam int TMO = 256;

  logic              aclk = 1'b0;
  logic              areset;
  logic              start;
  logic [IW:0]       num_entries;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [IW-1:0]     err_index;
  logic              tbl_en;
  logic [IW-1:0]     tbl_addr;
  logic [AW+DW-1:0]  tbl_rdata;
  logic [AW-1:0]     awaddr;
  logic [2:0]        awprot;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  always #5 aclk = ~aclk;

  axi4l_cfg_seq #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TBL_DEPTH_LOG2(IW), .C_TIMEOUT(TMO)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .num_entries(num_entries),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_index(err_index),
    .tbl_en(tbl_en), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  // Table memory, one cycle read latency
  logic [AW+DW-1:0] mem [0:255];
  always @(posedge aclk) if (tbl_en) tbl_rdata <= mem[tbl_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          err;
    logic [1:0]    code;
    logic [IW-1:0] idx;
    int            n;
  } status_t;

  logic [AW-1:0] exp_aw[$];
  logic [DW-1:0] exp_w[$];
  status_t       exp_st[$];
  bit            exp_tmo_chk = 0;

  // Slave configuration and bookkeeping
  int aw_delay = 0, w_delay = 0, max_delay = 0;
  int err_at = -1, hold_at = -1, hold_cycles = 0;
  logic [1:0] err_resp = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [AW-1:0] got_aw[$];
  logic [DW-1:0] got_w[$];
  logic [DW-1:0] regs[int];

  initial begin
    int aw_wait = 0, w_wait = 0, b_wait = 0;
    int aw_tgt = 0, w_tgt = 0, b_tgt = 0;
    bit aw_fire = 0, w_fire = 0, b_fire = 0, aw_act = 0, w_act = 0, b_arm = 0;
    logic [AW-1:0] aw_hold;
    logic [DW-1:0] w_hold;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; aw_act = 0; w_act = 0; b_arm = 0;
        continue;
      end
      if (aw_fire) chk("awvalid_drop", awvalid, 1'b0);
      if (w_fire)  chk("wvalid_drop", wvalid, 1'b0);
      aw_fire = 0; w_fire = 0; awready = 0; wready = 0;
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (aw_act) begin
        chk("awvalid_hold", awvalid, 1'b1);
        chk("awaddr_stable", awaddr, aw_hold);
      end
      if (w_act) begin
        chk("wvalid_hold", wvalid, 1'b1);
        chk("wdata_stable", wdata, w_hold);
      end
      // B only after both AW and W of the entry have completed
      if (!bvalid && b_cnt < aw_cnt && b_cnt < w_cnt) begin
        if (!b_arm) begin
          b_arm = 1; b_wait = 0;
          b_tgt = (b_cnt == hold_at) ? hold_cycles : int'($urandom_range(max_delay));
        end
        if (b_wait >= b_tgt) begin
          bvalid = 1; b_arm = 0;
          bresp = (b_cnt == err_at) ? err_resp : {1'b0, 1'($urandom)};
        end else b_wait++;
      end
      if (bvalid && bready) begin
        b_fire = 1;
        if (!bresp[1] && got_aw.size() > 0 && got_w.size() > 0)
          regs[int'(got_aw.pop_front())] = got_w.pop_front();
        b_cnt++;
      end
      if (awvalid) begin
        if (!aw_act) begin
          aw_act = 1; aw_wait = 0; aw_hold = awaddr;
          aw_tgt = (aw_delay >= 0) ? aw_delay : int'($urandom_range(max_delay));
        end
        if (aw_wait >= aw_tgt) begin
          awready = 1; aw_fire = 1; aw_act = 0; aw_cnt++;
          got_aw.push_back(awaddr);
          if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 'x);
          else chk("awaddr", awaddr, exp_aw.pop_front());
        end else aw_wait++;
      end
      if (wvalid) begin
        if (!w_act) begin
          w_act = 1; w_wait = 0; w_hold = wdata;
          w_tgt = (w_delay >= 0) ? w_delay : int'($urandom_range(max_delay));
        end
        if (w_wait >= w_tgt) begin
          wready = 1; w_fire = 1; w_act = 0; w_cnt++;
          got_w.push_back(wdata);
          if (exp_w.size() == 0) chk("w_unexpected", wdata, 'x);
          else chk("wdata", wdata, exp_w.pop_front());
        end else w_wait++;
      end
    end
  end

  // Status monitor: compares the final report whenever done rises
  initial begin
    logic done_q = 0, err_q = 0, awv_q = 0;
    int t = 0;
    status_t s;
    forever begin
      @(negedge aclk);
      if (awvalid && !awv_q) t = 0; else t++;
      if (err && !err_q && exp_tmo_chk) begin
        chk("tmo_latency", t, TMO);
        chk("tmo_bready_held", bready, 1'b1);
        chk("tmo_done_low", done, 1'b0);
      end
      if (done && !done_q) begin
        if (exp_st.size() == 0) chk("done_unexpected", done, 1'b0);
        else begin
          s = exp_st.pop_front();
          chk("err", err, s.err);
          chk("err_code", err_code, s.code);
          if (s.err) chk("err_index", err_index, s.idx);
          chk("aw_count", aw_cnt, s.n);
          chk("w_count", w_cnt, s.n);
          chk("b_count", b_cnt, s.n);
          chk("busy_at_done", busy, 1'b0);
        end
      end
      done_q = done; err_q = err; awv_q = awvalid;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin @(negedge aclk); k++; end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic prep(input int e_at, input logic [1:0] e_resp, input int h_at,
                      input int adly, input int wdly, input int mdly);
    err_at = e_at; err_resp = e_resp; hold_at = h_at; hold_cycles = 300;
    aw_delay = adly; w_delay = wdly; max_delay = mdly;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    got_aw.delete(); got_w.delete(); regs.delete();
    exp_aw.delete(); exp_w.delete(); exp_st.delete();
    exp_tmo_chk = 0;
  endtask

  task automatic wait_status();
    int k = 0;
    while (exp_st.size() > 0 && k < 5000) begin @(negedge aclk); k++; end
    if (exp_st.size() > 0) begin
      chk("run_timeout", exp_st.size(), 0);
      exp_st.delete();
    end
    chk("aw_leftover", exp_aw.size(), 0);
  endtask

  // Reference: entries go out in table order until the first error response
  // or the entry whose response is withheld past the timeout.
  task automatic run_seq(input int n, input int e_at, input logic [1:0] e_resp, input int h_at,
                         input int adly, input int wdly, input int mdly, input bit extra);
    status_t s;
    bit stop = 0;
    wait_idle();
    prep(e_at, e_resp, h_at, adly, wdly, mdly);
    s.err = 0; s.code = 2'b00; s.idx = '0; s.n = 0;
    for (int i = 0; i < n && !stop; i++) begin
      exp_aw.push_back(mem[i][AW+DW-1:DW]);
      exp_w.push_back(mem[i][DW-1:0]);
      s.n = i + 1;
      if (i == e_at && e_resp[1]) begin
        s.err = 1; s.code = (e_resp == 2'b10) ? 2'd1 : 2'd2; s.idx = IW'(i); stop = 1;
      end else if (i == h_at) begin
        s.err = 1; s.code = 2'd3; s.idx = IW'(i); stop = 1; exp_tmo_chk = 1;
      end
    end
    exp_st.push_back(s);
    @(negedge aclk);
    start = 1; num_entries = (IW+1)'(n);
    @(negedge aclk);
    start = 0; num_entries = (IW+1)'($urandom_range(1, 9));
    if (extra) begin
      repeat (2) @(negedge aclk);
      if (busy) begin
        start = 1; num_entries = 9'd5;
        @(negedge aclk);
        start = 0;
      end
    end
    wait_status();
  endtask

  initial begin
    areset = 1; start = 0; num_entries = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge aclk);
    chk("rst_busy", busy, 1'b0);      chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);        chk("rst_err_code", err_code, 2'b00);
    chk("rst_err_index", err_index, 0); chk("rst_tbl_en", tbl_en, 1'b0);
    chk("rst_tbl_addr", tbl_addr, 0); chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);  chk("rst_bready", bready, 1'b0);
    chk("rst_awaddr", awaddr, 0);     chk("rst_wdata", wdata, 0);
    chk("awprot", awprot, 3'b000);    chk("wstrb", wstrb, 4'hF);
    areset = 0;
    repeat (2) @(negedge aclk);

    mem[0] = {12'h000, 32'hABCD1234};
    mem[1] = {12'h008, 32'h5A5A0001};
    mem[2] = {12'h00C, 32'hFFFF0000};
    run_seq(3, -1, 2'b00, -1, 0, 0, 0, 0);
    chk("reg_a_b", regs[0], 32'hABCD1234);
    chk("reg_8", regs[8], 32'h5A5A0001);
    chk("reg_c", regs[12], 32'hFFFF0000);

    run_seq(3, -1, 2'b00, -1, 3, 0, 0, 0);
    run_seq(3, 1, 2'b11, -1, 0, 0, 0, 0);
    run_seq(2, -1, 2'b00, 0, 0, 0, 0, 0);

    // Empty table
    wait_idle();
    prep(-1, 2'b00, -1, 0, 0, 0);
    begin
      status_t s;
      s.err = 0; s.code = 2'b00; s.idx = '0; s.n = 0;
      exp_st.push_back(s);
    end
    @(negedge aclk);
    start = 1; num_entries = '0;
    @(negedge aclk);
    start = 0;
    chk("zero_busy", busy, 1'b1);
    chk("zero_done_clear", done, 1'b0);
    @(negedge aclk);
    chk("zero_done", done, 1'b1);
    chk("zero_busy_end", busy, 1'b0);
    chk("zero_awvalid", awvalid, 1'b0);
    wait_status();

    // Reset in the middle of ISSUE
    wait_idle();
    prep(-1, 2'b00, -1, 20, 20, 0);
    for (int i = 0; i < 4; i++) mem[i] = {12'($urandom), 32'($urandom)};
    @(negedge aclk);
    start = 1; num_entries = 9'd4;
    @(negedge aclk);
    start = 0;
    begin
      int k = 0;
      while (!awvalid && k < 20) begin @(negedge aclk); k++; end
      chk("issue_reached", awvalid, 1'b1);
    end
    @(negedge aclk);
    #2 areset = 1;
    #1;
    chk("arst_awvalid", awvalid, 1'b0);
    chk("arst_wvalid", wvalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    repeat (2) @(negedge aclk);
    areset = 0;
    run_seq(4, -1, 2'b00, -1, 0, 0, 0, 1);

    for (int r = 0; r < 20; r++) begin
      int n, e_at;
      logic [1:0] e_resp;
      for (int i = 0; i < 16; i++) mem[i] = {12'($urandom), 32'($urandom)};
      n = int'($urandom_range(1, 8));
      e_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      e_resp = 2'($urandom);
      run_seq(n, e_at, e_resp, -1, -1, -1, int'($urandom_range(0, 4)), 1'($urandom));
    end

    repeat (5) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
